// File: rtl/store_buffer_if.sv
// Handshake/bus bundle for store_buffer: MEM-stage store and load ports plus the drain bus.
interface store_buffer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            st_valid;
  logic [31:0]     st_addr;
  logic [3:0]      st_byteen;
  logic [31:0]     st_wdata;
  logic            st_ready;
  logic            ld_valid;
  logic [31:0]     ld_addr;
  logic            ld_stall;
  logic            ld_fwd_valid;
  logic [31:0]     ld_fwd_data;
  logic            bus_req;
  logic [31:0]     bus_addr;
  logic [3:0]      bus_byteen;
  logic [31:0]     bus_wdata;
  logic            bus_ack;
  logic            empty;
  logic [CntW-1:0] count;

  modport slave (
    input  st_valid, st_addr, st_byteen, st_wdata, ld_valid, ld_addr, bus_ack,
    output st_ready, ld_stall, ld_fwd_valid, ld_fwd_data, bus_req, bus_addr, bus_byteen,
           bus_wdata, empty, count
  );

  modport master (
    output st_valid, st_addr, st_byteen, st_wdata, ld_valid, ld_addr, bus_ack,
    input  st_ready, ld_stall, ld_fwd_valid, ld_fwd_data, bus_req, bus_addr, bus_byteen,
           bus_wdata, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the MEM store path and the data bus, with load-conflict stalling.
// Define STBUF_FWD_EN to forward full-word matches to loads instead of stalling them.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] TC_LO = 32'h0000_7f00,
  parameter logic [31:0] TC_HI = 32'h0000_7f1b
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave sb
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [29:0]     addr_q [DEPTH];
  logic [3:0]      be_q   [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;

  logic            empty, full, push, pop;
  logic            hit, in_tc, fwd_ok;
  logic [PtrW-1:0] hit_idx, idx;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));
  // st_ready looks only at registered count: a same-cycle pop never frees a slot early.
  assign push  = sb.st_valid && !full;
  assign pop   = !empty && sb.bus_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PtrW'(1);
      if (pop)  head_q <= head_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= sb.st_addr[31:2];
      be_q[tail_q]   <= sb.st_byteen;
      data_q[tail_q] <= sb.st_wdata;
    end
  end

  // Walk from oldest to youngest so the last hit wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PtrW'(k);
      if ((CntW'(k) < count_q) && (addr_q[idx] == sb.ld_addr[31:2])) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  assign in_tc = (sb.ld_addr >= TC_LO) && (sb.ld_addr <= TC_HI);

`ifdef STBUF_FWD_EN
  logic unused_bits;
  assign unused_bits     = ^sb.st_addr[1:0];
  assign fwd_ok          = hit && (be_q[hit_idx] == 4'b1111) && !in_tc;
  assign sb.ld_fwd_valid = sb.ld_valid && fwd_ok;
  assign sb.ld_fwd_data  = (sb.ld_valid && fwd_ok) ? data_q[hit_idx] : '0;
`else
  logic unused_bits;
  assign unused_bits     = ^{sb.st_addr[1:0], hit_idx};
  assign fwd_ok          = 1'b0;
  assign sb.ld_fwd_valid = 1'b0;
  assign sb.ld_fwd_data  = '0;
`endif

  assign sb.ld_stall = sb.ld_valid &&
                       ((hit && !fwd_ok) || (in_tc && !empty) || sb.st_valid);

  assign sb.st_ready   = !full;
  assign sb.empty      = empty;
  assign sb.count      = count_q;
  assign sb.bus_req    = !empty;
  assign sb.bus_addr   = empty ? 32'h0 : {addr_q[head_q], 2'b00};
  assign sb.bus_byteen = empty ? 4'h0  : be_q[head_q];
  assign sb.bus_wdata  = empty ? 32'h0 : data_q[head_q];
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_store_buffer;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] TC_LO = 32'h0000_7f00;
  localparam logic [31:0] TC_HI = 32'h0000_7f1b;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH)) sb ();

  store_buffer #(.DEPTH(DEPTH), .TC_LO(TC_LO), .TC_HI(TC_HI)) dut (
    .clk  (clk),
    .reset(reset),
    .sb   (sb)
  );

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } entry_t;

  entry_t q[$];
  bit     model_ok = 0;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of committed stores.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      model_ok = 1;
    end else if (model_ok) begin
      bit do_pop, do_push;
      entry_t e;
      do_pop  = (q.size() != 0) && (sb.bus_ack === 1'b1);
      do_push = (sb.st_valid === 1'b1) && (q.size() < DEPTH);
      e.addr = sb.st_addr[31:2];
      e.be   = sb.st_byteen;
      e.data = sb.st_wdata;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      bit a, in_tc, fwd, stall;
      int yi;
      logic [31:0] ea, ed;
      logic [3:0] eb;
      a = 0;
      yi = -1;
      foreach (q[i]) if (q[i].addr == sb.ld_addr[31:2]) begin a = 1; yi = i; end
      in_tc = (sb.ld_addr >= TC_LO) && (sb.ld_addr <= TC_HI);
`ifdef STBUF_FWD_EN
      fwd = (yi >= 0) && (q[yi].be == 4'hf) && !in_tc;
`else
      fwd = 0;
`endif
      stall = sb.ld_valid && ((a && !fwd) || (in_tc && q.size() != 0) || sb.st_valid);
      ea = (q.size() != 0) ? {q[0].addr, 2'b00} : 32'h0;
      eb = (q.size() != 0) ? q[0].be : 4'h0;
      ed = (q.size() != 0) ? q[0].data : 32'h0;
      chk("m_count", 32'(sb.count), 32'(q.size()));
      chk("m_empty", 32'(sb.empty), 32'(q.size() == 0));
      chk("m_st_ready", 32'(sb.st_ready), 32'(q.size() < DEPTH));
      chk("m_bus_req", 32'(sb.bus_req), 32'(q.size() != 0));
      chk("m_bus_addr", sb.bus_addr, ea);
      chk("m_bus_byteen", 32'(sb.bus_byteen), 32'(eb));
      chk("m_bus_wdata", sb.bus_wdata, ed);
      chk("m_ld_stall", 32'(sb.ld_stall), 32'(stall));
      chk("m_ld_fwd_valid", 32'(sb.ld_fwd_valid), 32'(sb.ld_valid && fwd));
      chk("m_ld_fwd_data", sb.ld_fwd_data, (sb.ld_valid && fwd) ? q[yi].data : 32'h0);
    end
  end

  task automatic set_in(input bit sv, input logic [31:0] sa, input logic [3:0] sbe,
                        input logic [31:0] sd, input bit ack, input bit lv,
                        input logic [31:0] la);
    sb.st_valid  = sv;
    sb.st_addr   = sa;
    sb.st_byteen = sbe;
    sb.st_wdata  = sd;
    sb.bus_ack   = ack;
    sb.ld_valid  = lv;
    sb.ld_addr   = la;
  endtask

  task automatic idle(input bit ack);
    set_in(0, 32'h0, 4'h0, 32'h0, ack, 0, 32'h0);
  endtask

  task automatic to_neg;
    @(negedge clk);
  endtask

  task automatic to_next;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] seen[$];
  int cnt_seq[7] = '{1, 2, 2, 2, 2, 1, 0};

  initial begin
    idle(0);
    to_next;
    to_next;
    reset = 0;

    // Reset state
    to_neg;
    chk("rst_count", 32'(sb.count), 32'd0);
    chk("rst_empty", 32'(sb.empty), 32'd1);
    chk("rst_st_ready", 32'(sb.st_ready), 32'd1);
    chk("rst_bus_req", 32'(sb.bus_req), 32'd0);
    chk("rst_bus_addr", sb.bus_addr, 32'h0);
    chk("rst_fwd_data", sb.ld_fwd_data, 32'h0);
    to_next;

    // Two stores, ack held low three cycles
    set_in(1, 32'h10, 4'hf, 32'hDEADBEEF, 0, 0, 0);
    to_neg;
    to_next;
    set_in(1, 32'h21, 4'b0010, 32'h0000_AB00, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      to_neg;
      chk("seq_count", 32'(sb.count), 32'(cnt_seq[i]));
      if (i >= 1 && i <= 4) begin
        chk("seq_head_addr", sb.bus_addr, 32'h10);
        chk("seq_head_data", sb.bus_wdata, 32'hDEADBEEF);
      end
      if (i == 5) begin
        chk("seq_2nd_addr", sb.bus_addr, 32'h20);
        chk("seq_2nd_be", 32'(sb.bus_byteen), 32'h2);
        chk("seq_2nd_data", sb.bus_wdata, 32'h0000_AB00);
      end
      to_next;
      idle(i >= 3);
    end
    idle(0);

    // Fill to DEPTH, then a dropped 5th store
    for (int i = 0; i < 4; i++) begin
      set_in(1, 32'h100 + 32'(i * 4), 4'hf, 32'hA000 + 32'(i), 0, 0, 0);
      to_neg;
      to_next;
    end
    idle(0);
    to_neg;
    chk("full_st_ready", 32'(sb.st_ready), 32'd0);
    chk("full_count", 32'(sb.count), 32'd4);
    to_next;
    set_in(1, 32'h300, 4'hf, 32'h5555, 0, 0, 0);
    to_neg;
    to_next;
    idle(1);
    to_neg;
    chk("drop_count", 32'(sb.count), 32'd4);
    chk("drop_head", sb.bus_addr, 32'h100);
    chk("nobypass_ready", 32'(sb.st_ready), 32'd0);
    to_next;
    idle(0);
    to_neg;
    chk("ack_st_ready", 32'(sb.st_ready), 32'd1);
    chk("ack_count", 32'(sb.count), 32'd3);
    to_next;
    idle(1);
    for (int i = 0; i < 3; i++) begin to_neg; to_next; end
    idle(0);

    // Load conflict against 0x40
    set_in(1, 32'h40, 4'hf, 32'h1234_5678, 0, 0, 0);
    to_neg;
    to_next;
    set_in(0, 0, 0, 0, 0, 1, 32'h44);
    to_neg;
    chk("ld44_stall", 32'(sb.ld_stall), 32'd0);
    to_next;
    set_in(0, 0, 0, 0, 0, 1, 32'h42);
    to_neg;
    chk("ld42_stall", 32'(sb.ld_stall), 32'd1);
    to_next;
    set_in(0, 0, 0, 0, 0, 1, 32'h40);
    to_neg;
`ifdef STBUF_FWD_EN
    chk("ld40_stall", 32'(sb.ld_stall), 32'd0);
    chk("ld40_fwd_valid", 32'(sb.ld_fwd_valid), 32'd1);
    chk("ld40_fwd_data", sb.ld_fwd_data, 32'h1234_5678);
`else
    chk("ld40_stall", 32'(sb.ld_stall), 32'd1);
    chk("ld40_fwd_valid", 32'(sb.ld_fwd_valid), 32'd0);
`endif
    to_next;
    set_in(0, 0, 0, 0, 1, 1, 32'h42);
    to_neg;
    chk("ld42_pop_stall", 32'(sb.ld_stall), 32'd1);
    to_next;
    set_in(0, 0, 0, 0, 0, 1, 32'h42);
    to_neg;
    chk("ld42_release", 32'(sb.ld_stall), 32'd0);
    to_next;

    // Timer ordering
    set_in(1, 32'h100, 4'hf, 32'h77, 0, 0, 0);
    to_neg;
    to_next;
    set_in(0, 0, 0, 0, 0, 1, 32'h7f04);
    to_neg;
    chk("tc_stall", 32'(sb.ld_stall), 32'd1);
    to_next;
    set_in(0, 0, 0, 0, 1, 1, 32'h7f04);
    to_neg;
    chk("tc_pop_stall", 32'(sb.ld_stall), 32'd1);
    to_next;
    set_in(0, 0, 0, 0, 0, 1, 32'h7f04);
    to_neg;
    chk("tc_empty_stall", 32'(sb.ld_stall), 32'd0);
    to_next;

    // Streaming over the pointer wrap
    for (int i = 0; i < 10; i++) begin
      set_in(1, 32'h200 + 32'(i * 16), 4'hf, 32'(i), 1, 0, 0);
      to_neg;
      chk("stream_count_le1", 32'(sb.count <= 1), 32'd1);
      if (sb.bus_req) seen.push_back(sb.bus_addr);
      to_next;
    end
    idle(1);
    for (int i = 0; i < 8 && sb.count != 0; i++) begin
      to_neg;
      if (sb.bus_req) seen.push_back(sb.bus_addr);
      to_next;
    end
    chk("stream_len", 32'(seen.size()), 32'd10);
    foreach (seen[i]) chk("stream_order", seen[i], 32'h200 + 32'(i * 16));
    idle(0);

    // Reset mid-handshake
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h400 + 32'(i * 4), 4'hf, 32'h9, 0, 0, 0);
      to_neg;
      to_next;
    end
    idle(0);
    to_neg;
    chk("pre_rst_count", 32'(sb.count), 32'd3);
    chk("pre_rst_req", 32'(sb.bus_req), 32'd1);
    reset = 1;
    to_next;
    reset = 0;
    to_neg;
    chk("post_rst_req", 32'(sb.bus_req), 32'd0);
    chk("post_rst_count", 32'(sb.count), 32'd0);
    chk("post_rst_ready", 32'(sb.st_ready), 32'd1);
    to_next;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pool[8];
      logic [3:0] be;
      pool = '{32'h40, 32'h44, 32'h48, 32'h100, 32'h7f00, 32'h7f18, 32'h7f1c, 32'h7efc};
      be = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 2) == 0) be = 4'hf;
      set_in($urandom_range(0, 2) == 0, pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)),
             be, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
             pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)));
      reset = ($urandom_range(0, 199) == 0);
      to_neg;
      to_next;
    end
    reset = 0;
    idle(0);
    to_neg;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the MEM stage store path and the shared data bus (DM, TC0, TC1, stall register).
- Accepts already lane-aligned, exception-free stores (byte enables and shifted data) and queues them in a small in-order FIFO.
- Drains the FIFO one entry at a time over a req/ack bus handshake.
- Stalls MEM-stage loads that would read stale data or bypass a pending peripheral write.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..8
- TC_LO, 32'h0000_7f00, lowest timer address (TC0 start)
- TC_HI, 32'h0000_7f1b, highest timer address (TC1 end)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- st_valid  in  1  store request from MEM stage
- st_addr  in  32  store byte address; only [31:2] is stored
- st_byteen  in  4  lane enables, nonzero when st_valid
- st_wdata  in  32  lane-aligned write data
- st_ready  out  1  entry available (count < DEPTH)
- ld_valid  in  1  load request from MEM stage
- ld_addr  in  32  load byte address
- ld_stall  out  1  combinational load hold
- ld_fwd_valid  out  1  forwarded load data valid
- ld_fwd_data  out  32  forwarded word
- bus_req  out  1  head entry presented to bus
- bus_addr  out  32  {head addr[31:2], 2'b00}
- bus_byteen  out  4  head byte enables
- bus_wdata  out  32  head data
- bus_ack  in  1  bus accepted head this cycle
- empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  valid entries

## Operation
- **Enqueue:** on st_valid && st_ready, write {addr[31:2], byteen, wdata} at the tail; the tail pointer wraps modulo DEPTH.
- **Full:** st_valid with !st_ready is a protocol error; the store is dropped and state is unchanged. The pipeline must hold on !st_ready.
- **Drain:** bus_req = !empty; bus_addr, bus_byteen and bus_wdata come from the head entry and are held stable while bus_req && !bus_ack.
- **Pop:** on bus_req && bus_ack, advance the head pointer. bus_ack while !bus_req is ignored.
- **Simultaneous enqueue and pop:** count is unchanged and both pointers advance.
- **No full-bypass:** st_ready depends only on registered count, so a pop in the same cycle does not make st_ready rise early.
- **Empty outputs:** bus_addr, bus_byteen and bus_wdata read 0 when empty.
- **Load conflict.** ld_stall = ld_valid && (A || B || C), all terms evaluated on registered state:
  - A: any valid entry with addr[31:2] == ld_addr[31:2].
  - B: ld_addr in [TC_LO, TC_HI] && !empty. Timer accesses are strongly ordered.
  - C: st_valid also asserted. The store has priority and the load is held.
- Entries are committed stores; nothing flushes them except reset.

## Timing
- Reset values: count 0, empty 1, st_ready 1, bus_req 0, bus_* 0, ld_stall 0, ld_fwd_valid 0, ld_fwd_data 0. Pointers are 0.
- Reset mid-handshake drops all entries, including an unacknowledged head; bus_req is 0 in the cycle after the reset edge.
- **Latency:** a store enqueued at edge N into an empty buffer drives bus_req = 1 from cycle N+1. With bus_ack held high the buffer drains one entry per cycle.
- **ld_stall:** combinational from ld_valid, ld_addr, st_valid and registered state; no registered delay. A stalled load re-evaluates each cycle and releases in the cycle after the last conflicting entry pops.
- st_ready, empty and count are registered-state outputs with no combinational path from st_valid or bus_ack.

## Configuration
- Macro: STBUF_FWD_EN.
- **Defined:**
  - Take the youngest valid entry whose addr[31:2] matches ld_addr[31:2].
  - Forwarding condition: that entry's byteen == 4'b1111 and the load is outside [TC_LO, TC_HI].
  - When the condition holds, term A is suppressed, ld_fwd_valid = 1 and ld_fwd_data = that entry's data.
  - A partial-byteen youngest match still stalls.
  - Terms B and C are unaffected.
- **Undefined:** ld_fwd_valid and ld_fwd_data are tied to 0, and every match stalls.

## Test plan
- **Reset, then two stores:** store sw 0x10 = 0xDEADBEEF, then sb 0x21 with byteen 0010 and data 0x0000_AB00; hold bus_ack = 0 for 3 cycles, then 1.
  - Required: bus shows 0x10/1111 first, stable until ack; then 0x20/0010/0x0000AB00.
  - Required: count sequence 1, 2, 2, 2, 2, 1, 0.
- **Fill to DEPTH = 4 with bus_ack = 0:** st_ready = 0 after the 4th store. Assert a 5th st_valid and check count stays 4. Ack once, then check st_ready = 1 on the next cycle.
- **Buffer holds 0x40 (1111):** load 0x44 gives ld_stall = 0; load 0x42 gives ld_stall = 1 until the pop cycle; with STBUF_FWD_EN, load 0x40 gives ld_stall = 0, ld_fwd_valid = 1 and the stored word.
- **Buffer holds DM store 0x100:** load 0x7f04 gives ld_stall = 1 until empty. With the buffer empty, load 0x7f04 gives ld_stall = 0.
- **Simultaneous enqueue and pop over wrap:** run 10 stores with bus_ack high every cycle. Count stays ≤ 1 and the bus order equals the issue order, including across the pointer wrap.
- **Reset asserted while bus_req = 1 and count = 3:** the cycle after, bus_req = 0, count = 0 and st_ready = 1.
